shift_seq_unit: RTL and testbench

//  Parametrised multi-mode shift register for the processor datapath. It supports parallel

---
 rtl/shift_pkg.sv | 8 +
 rtl/shift_step.sv | 41 ++++
 rtl/shift_seq_unit.sv | 98 +++++++++
 tb/tb_shift_seq_unit.sv | 189 ++++++++++++++++++
 4 files changed

// File: rtl/shift_pkg.sv
// rtl/shift_pkg.sv - shared types for the sequenced shift unit
package shift_pkg;

  typedef enum logic [1:0] {OP_SLL, OP_SRL, OP_SRA, OP_ROR} shift_op_t;

  typedef enum logic {S_IDLE, S_SHIFT} shift_state_t;

endpackage

// File: rtl/shift_step.sv
// rtl/shift_step.sv - one-position combinational shift/rotate step
module shift_step
  import shift_pkg::*;
#(
  parameter int WIDTH = 6
) (
  input  logic [WIDTH-1:0] d,
  input  shift_op_t        op,
  input  logic             sin,
  output logic [WIDTH-1:0] q,
  output logic             sout
);

  always_comb begin
    q    = d;
    sout = 1'b0;
    case (op)
      OP_SLL: begin
        q    = {d[WIDTH-2:0], sin};
        sout = d[WIDTH-1];
      end
      OP_SRL: begin
        q    = {sin, d[WIDTH-1:1]};
        sout = d[0];
      end
      OP_SRA: begin
        q    = {d[WIDTH-1], d[WIDTH-1:1]};
        sout = d[0];
      end
      OP_ROR: begin
        q    = {d[0], d[WIDTH-1:1]};
        sout = d[0];
      end
      default: begin
        q    = d;
        sout = 1'b0;
      end
    endcase
  end

endmodule

// File: rtl/shift_seq_unit.sv
// rtl/shift_seq_unit.sv - multi-mode shift register stepping one position per enabled cycle
module shift_seq_unit
  import shift_pkg::*;
#(
  parameter int WIDTH = 6,
  localparam int CNT_W = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             load,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [CNT_W-1:0] amt,
  input  logic             sin,
  input  logic [WIDTH-1:0] in,
  output logic [WIDTH-1:0] out,
  output logic             sout,
  output logic             busy,
  output logic             done
);

  shift_state_t     state, state_n;
  shift_op_t        op_q, op_n;
  logic [CNT_W-1:0] cnt, cnt_n;
  logic [WIDTH-1:0] out_q, out_n, step_q;
  logic             sout_q, sout_n, step_sout;
  logic             done_q, done_n;

  shift_step #(.WIDTH(WIDTH)) u_step (
    .d    (out_q),
    .op   (op_q),
    .sin  (sin),
    .q    (step_q),
    .sout (step_sout)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= S_IDLE;
      op_q   <= OP_SLL;
      cnt    <= '0;
      out_q  <= '0;
      sout_q <= 1'b0;
      done_q <= 1'b0;
    end else if (en) begin
      state  <= state_n;
      op_q   <= op_n;
      cnt    <= cnt_n;
      out_q  <= out_n;
      sout_q <= sout_n;
      done_q <= done_n;
    end
  end

  always_comb begin
    state_n = state;
    op_n    = op_q;
    cnt_n   = cnt;
    out_n   = out_q;
    sout_n  = sout_q;
    done_n  = 1'b0;
    case (state)
      S_IDLE: begin
        if (load) begin
          out_n  = in;
          sout_n = 1'b0;
        end else if (start) begin
          if (amt != '0) begin
            op_n    = shift_op_t'(op);
            cnt_n   = amt;
            state_n = S_SHIFT;
          end else begin
            // A zero-length shift completes immediately without touching OUT.
            done_n = 1'b1;
            sout_n = 1'b0;
          end
        end
      end
      S_SHIFT: begin
        out_n  = step_q;
        sout_n = step_sout;
        cnt_n  = cnt - CNT_W'(1);
        if (cnt == CNT_W'(1)) begin
          state_n = S_IDLE;
          done_n  = 1'b1;
        end
      end
      default: state_n = S_IDLE;
    endcase
  end

  assign out  = out_q;
  assign sout = sout_q;
  assign busy = (state == S_SHIFT);
  assign done = done_q;

endmodule

// File: tb/tb_shift_seq_unit.sv
// tb/tb_shift_seq_unit.sv - directed vector bench for shift_seq_unit at WIDTH=6
module tb_shift_seq_unit;

  logic       clk = 1'b0;
  logic       rst, en, load, start, sin;
  logic [1:0] op;
  logic [2:0] amt;
  logic [5:0] in;
  logic [5:0] out;
  logic       sout, busy, done;

  int checks = 0;
  int errors = 0;
  int cyc;
  logic seen_done;

  typedef struct {
    logic [5:0] pre;
    logic [1:0] op;
    logic [2:0] amt;
    logic       sin;
    logic       noise;
    logic [5:0] exp_out;
    logic       exp_sout;
  } vec_t;

  vec_t vec [8];

  shift_seq_unit #(.WIDTH(6)) dut (
    .clk   (clk),
    .rst   (rst),
    .en    (en),
    .load  (load),
    .start (start),
    .op    (op),
    .amt   (amt),
    .sin   (sin),
    .in    (in),
    .out   (out),
    .sout  (sout),
    .busy  (busy),
    .done  (done)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic do_load(input logic [5:0] v);
    load = 1'b1;
    in   = v;
    tick();
    load = 1'b0;
  endtask

  task automatic wait_done(input int limit);
    cyc = 0;
    while (!done && cyc < limit) begin
      tick();
      cyc++;
    end
  endtask

  initial begin
    vec[0] = '{6'b101101, 2'b00, 3'd2, 1'b0, 1'b0, 6'b110100, 1'b0};
    vec[1] = '{6'b100110, 2'b10, 3'd3, 1'b0, 1'b0, 6'b111100, 1'b1};
    vec[2] = '{6'b000001, 2'b11, 3'd7, 1'b0, 1'b1, 6'b100000, 1'b1};
    vec[3] = '{6'b101101, 2'b01, 3'd3, 1'b1, 1'b1, 6'b111101, 1'b1};
    vec[4] = '{6'b110011, 2'b00, 3'd7, 1'b0, 1'b0, 6'b000000, 1'b0};
    vec[5] = '{6'b100000, 2'b10, 3'd7, 1'b0, 1'b0, 6'b111111, 1'b1};
    vec[6] = '{6'b011010, 2'b11, 3'd1, 1'b0, 1'b0, 6'b001101, 1'b0};
    vec[7] = '{6'b010101, 2'b01, 3'd1, 1'b0, 1'b0, 6'b001010, 1'b1};

    rst = 1'b1; en = 1'b1; load = 1'b1; start = 1'b0;
    op = 2'b00; amt = 3'd0; sin = 1'b0; in = 6'b101101;
    tick();
    chk("reset_out", out, 6'b000000);
    chk("reset_busy", busy, 1'b0);
    chk("reset_done", done, 1'b0);
    chk("reset_sout", sout, 1'b0);
    rst = 1'b0;
    tick();
    load = 1'b0;
    chk("load_out", out, 6'b101101);
    chk("load_busy", busy, 1'b0);

    for (int i = 0; i < 8; i++) begin
      do_load(vec[i].pre);
      op = vec[i].op; amt = vec[i].amt; sin = vec[i].sin; start = 1'b1;
      tick();
      start = 1'b0;
      chk("busy_after_start", busy, 1'b1);
      cyc = 0;
      while (!done && cyc < 40) begin
        if (vec[i].noise) begin
          start = 1'b1; load = 1'b1; op = 2'b00; amt = 3'd1; in = 6'b000000;
        end
        tick();
        cyc++;
      end
      start = 1'b0; load = 1'b0;
      chk($sformatf("vec%0d_cycles", i), cyc, vec[i].amt);
      chk($sformatf("vec%0d_out", i), out, vec[i].exp_out);
      chk($sformatf("vec%0d_sout", i), sout, vec[i].exp_sout);
      chk($sformatf("vec%0d_busy_at_done", i), busy, 1'b0);
      tick();
      chk($sformatf("vec%0d_done_pulse", i), done, 1'b0);
    end

    // zero-length shift completes next cycle with OUT untouched
    do_load(6'b011100);
    start = 1'b1; amt = 3'd0; op = 2'b01;
    tick();
    start = 1'b0;
    chk("amt0_done", done, 1'b1);
    chk("amt0_out", out, 6'b011100);
    chk("amt0_busy", busy, 1'b0);
    chk("amt0_sout", sout, 1'b0);
    tick();
    chk("amt0_done_clear", done, 1'b0);

    // load wins over a simultaneous start
    load = 1'b1; in = 6'b010011; start = 1'b1; amt = 3'd3;
    tick();
    load = 1'b0; start = 1'b0;
    chk("ldst_out", out, 6'b010011);
    chk("ldst_busy", busy, 1'b0);
    tick();
    chk("ldst_busy2", busy, 1'b0);
    chk("ldst_out2", out, 6'b010011);

    // SLL by 5 with a three-cycle enable stall after two steps
    do_load(6'b101101);
    op = 2'b00; amt = 3'd5; sin = 1'b1; start = 1'b1;
    tick();
    start = 1'b0;
    tick();
    tick();
    chk("stall_mid_out", out, 6'b110111);
    en = 1'b0;
    for (int k = 0; k < 3; k++) begin
      tick();
      chk("stall_hold_out", out, 6'b110111);
      chk("stall_hold_busy", busy, 1'b1);
      chk("stall_hold_done", done, 1'b0);
    end
    en = 1'b1;
    wait_done(20);
    chk("stall_cycles", cyc, 3);
    chk("stall_out", out, 6'b111111);
    chk("stall_sout", sout, 1'b0);

    // reset mid-run aborts without a done pulse
    tick();
    do_load(6'b111111);
    op = 2'b01; amt = 3'd5; sin = 1'b0; start = 1'b1;
    tick();
    start = 1'b0;
    tick();
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("rstmid_out", out, 6'b000000);
    chk("rstmid_busy", busy, 1'b0);
    seen_done = 1'b0;
    for (int k = 0; k < 6; k++) begin
      tick();
      if (done) seen_done = 1'b1;
    end
    chk("rstmid_no_done", seen_done, 1'b0);
    chk("rstmid_out_after", out, 6'b000000);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
